// File: rtl/alu_seq_unit.sv
// Multi-beat ALU (binary/BCD add-sub, logic, shifts), one DATA_W slice per clock, carry chained between slices.
// Latency: done pulses nbeats edges after start is sampled; start is ignored while busy (no other backpressure).
module alu_seq_unit #(
  parameter int DATA_W  = 8,
  parameter int BEATS   = 2,
  parameter int DECIMAL = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [2:0]                   op,
  input  logic                         sub,
  input  logic                         dec_en,
  input  logic [$clog2(BEATS+1)-1:0]   nbeats,
  input  logic [DATA_W*BEATS-1:0]      a,
  input  logic [DATA_W*BEATS-1:0]      b,
  input  logic                         c_in,
  output logic                         busy,
  output logic                         done,
  output logic [DATA_W*BEATS-1:0]      result,
  output logic                         c_out,
  output logic                         v_out,
  output logic                         n_out,
  output logic                         z_out
);

  localparam int W    = DATA_W * BEATS;
  localparam int NB_W = $clog2(BEATS + 1);
  localparam bit HAS_BCD = (DECIMAL != 0);

  localparam logic [2:0] OP_ORA  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_EOR  = 3'd2;
  localparam logic [2:0] OP_ADC  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ORA2 = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              dec_q, dec_d, sub_q, sub_d, carry_q, carry_d, z_acc_q, z_acc_d;
  logic [NB_W-1:0]   nb_q, nb_d, cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              c_out_q, c_out_d, v_out_q, v_out_d, n_out_q, n_out_d, z_out_q, z_out_d;

  logic              msb_first, last_beat, sl_cout, pre_msb, nc;
  logic [NB_W-1:0]   idx, nb_clamp;
  logic [DATA_W-1:0] a_sl, b_sl, sl_res;
  logic [4:0]        nsum;
  logic [3:0]        nib;

  // Slice datapath: one slice selected by idx, carry-in from the previous beat.
  always_comb begin
    msb_first = (op_q == OP_SHR) || (op_q == OP_ASR);
    last_beat = (cnt_q == nb_q - NB_W'(1));
    idx       = msb_first ? (nb_q - NB_W'(1) - cnt_q) : cnt_q;
    a_sl      = '0;
    b_sl      = '0;
    for (int s = 0; s < BEATS; s++) begin
      if (NB_W'(s) == idx) begin
        a_sl = a_q[s*DATA_W +: DATA_W];
        b_sl = b_q[s*DATA_W +: DATA_W];
      end
    end
    sl_res  = '0;
    sl_cout = carry_q;
    pre_msb = 1'b0;
    nc      = carry_q;
    nsum    = '0;
    nib     = '0;
    case (op_q)
      OP_AND: sl_res = a_sl & b_sl;
      OP_EOR: sl_res = a_sl ^ b_sl;
      OP_ADC: begin
        for (int n = 0; n < DATA_W/4; n++) begin
          nsum    = {1'b0, a_sl[4*n +: 4]} + {1'b0, b_sl[4*n +: 4]} + {4'b0, nc};
          pre_msb = nsum[3];
          nib     = nsum[3:0];
          if (dec_q && !sub_q) begin
            nc = nsum[4] | (nsum > 5'd9);
            if (nc) nib = nsum[3:0] + 4'd6;
          end else if (dec_q) begin
            nc = nsum[4];
            if (!nc) nib = nsum[3:0] + 4'hA;
          end else begin
            nc = nsum[4];
          end
          sl_res[4*n +: 4] = nib;
        end
        sl_cout = nc;
      end
      OP_SHL: {sl_cout, sl_res} = {a_sl, carry_q};
      OP_SHR: {sl_res, sl_cout} = {carry_q, a_sl};
      // The top slice is processed first and feeds back its own sign bit.
      OP_ASR: {sl_res, sl_cout} = {((cnt_q == '0) ? a_sl[DATA_W-1] : carry_q), a_sl};
      default: sl_res = a_sl | b_sl;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    dec_d    = dec_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    z_acc_d  = z_acc_q;
    nb_d     = nb_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    v_out_d  = v_out_q;
    n_out_d  = n_out_q;
    z_out_d  = z_out_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    nb_clamp = (nbeats == '0) ? NB_W'(1) :
               (nbeats > NB_W'(BEATS)) ? NB_W'(BEATS) : nbeats;
    case (state_q)
      S_RUN: begin
        busy_d = 1'b1;
        for (int s = 0; s < BEATS; s++) begin
          if (NB_W'(s) == idx) work_d[s*DATA_W +: DATA_W] = sl_res;
        end
        carry_d = sl_cout;
        z_acc_d = z_acc_q & (sl_res == '0);
        cnt_d   = cnt_q + NB_W'(1);
        if (last_beat) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = work_d;
          c_out_d  = sl_cout;
          v_out_d  = (op_q == OP_ADC) && (a_sl[DATA_W-1] == b_sl[DATA_W-1]) &&
                     (a_sl[DATA_W-1] != pre_msb);
          z_out_d  = z_acc_d;
          n_out_d  = 1'b0;
          for (int s = 0; s < BEATS; s++) begin
            if (NB_W'(s) == nb_q - NB_W'(1)) n_out_d = work_d[s*DATA_W + DATA_W - 1];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = (sub && op == OP_ADC) ? ~b : b;
          op_d    = op;
          dec_d   = dec_en & HAS_BCD;
          sub_d   = sub;
          carry_d = c_in;
          nb_d    = nb_clamp;
          cnt_d   = '0;
          z_acc_d = 1'b1;
          work_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ORA;
      dec_q    <= 1'b0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      z_acc_q  <= 1'b1;
      nb_q     <= NB_W'(1);
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      v_out_q  <= 1'b0;
      n_out_q  <= 1'b0;
      z_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      z_acc_q  <= z_acc_d;
      nb_q     <= nb_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      v_out_q  <= v_out_d;
      n_out_q  <= n_out_d;
      z_out_q  <= z_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign v_out  = v_out_q;
  assign n_out  = n_out_q;
  assign z_out  = z_out_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (DATA_W=8, BEATS=2): whole-word arithmetic model, decoupled done monitor.
module tb_alu_seq_unit;

  localparam logic [2:0] OP_ORA  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_EOR  = 3'd2;
  localparam logic [2:0] OP_ADC  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, start, sub, dec_en, c_in;
  logic [2:0]  op;
  logic [1:0]  nbeats;
  logic [15:0] a, b;
  logic        busy, done, c_out, v_out, n_out, z_out;
  logic [15:0] result;

  int   compared = 0;
  int   failed   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t me;
  exp_t left;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_unit #(.DATA_W(8), .BEATS(2), .DECIMAL(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .sub(sub), .dec_en(dec_en),
    .nbeats(nbeats), .a(a), .b(b), .c_in(c_in), .busy(busy), .done(done),
    .result(result), .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int eff_nb(input logic [1:0] n);
    if (n == 2'd0) return 1;
    if (n > 2'd2) return 2;
    return int'(n);
  endfunction

  // Whole-word reference: binary ops on the masked operand, BCD as decimal digit arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic s, input logic d, input int nb,
                                 input logic [15:0] aa, input logic [15:0] bb, input logic ci);
    exp_t   e;
    int     bits, carry, ad, bd, sm, diff;
    longint m, av, bv, be, r, sum;
    logic   pre_top, amsb, bmsb;
    bits    = nb * 8;
    m       = (longint'(1) << bits) - 1;
    av      = longint'(aa) & m;
    bv      = longint'(bb) & m;
    be      = (o == OP_ADC && s) ? (~bv & m) : bv;
    r       = 0;
    carry   = int'(ci);
    pre_top = 1'b0;
    case (o)
      OP_AND: r = av & bv;
      OP_EOR: r = av ^ bv;
      OP_SHL: begin
        r     = ((av << 1) | longint'(ci)) & m;
        carry = int'((av >> (bits - 1)) & 1);
      end
      OP_SHR: begin
        r     = (av >> 1) | (longint'(ci) << (bits - 1));
        carry = int'(av & 1);
      end
      OP_ASR: begin
        r     = (av >> 1) | (av & (longint'(1) << (bits - 1)));
        carry = int'(av & 1);
      end
      OP_ADC: begin
        if (!d) begin
          sum     = av + be + longint'(ci);
          r       = sum & m;
          carry   = int'((sum >> bits) & 1);
          pre_top = ((r >> (bits - 1)) & 1) != 0;
        end else begin
          for (int i = 0; i < bits / 4; i++) begin
            ad = int'((av >> (4 * i)) & 15);
            bd = int'((bv >> (4 * i)) & 15);
            if (!s) begin
              sm      = ad + bd + carry;
              pre_top = (sm & 8) != 0;
              if (sm > 9) begin
                r |= longint'((sm + 6) & 15) << (4 * i);
                carry = 1;
              end else begin
                r |= longint'(sm) << (4 * i);
                carry = 0;
              end
            end else begin
              diff    = ad - bd - (1 - carry);
              pre_top = ((ad + (15 - bd) + carry) & 8) != 0;
              if (diff < 0) begin
                r |= longint'((diff + 10) & 15) << (4 * i);
                carry = 0;
              end else begin
                r |= longint'(diff) << (4 * i);
                carry = 1;
              end
            end
          end
        end
      end
      default: r = av | bv;
    endcase
    amsb  = ((av >> (bits - 1)) & 1) != 0;
    bmsb  = ((be >> (bits - 1)) & 1) != 0;
    e.res = 16'(r);
    e.c   = (carry != 0);
    e.v   = (o == OP_ADC) && (amsb == bmsb) && (amsb != pre_top);
    e.n   = ((r >> (bits - 1)) & 1) != 0;
    e.z   = (r == 0);
    e.cyc = '0;
    return e;
  endfunction

  function automatic exp_t expect_at(input logic [2:0] o, input logic s, input logic d,
                                     input logic [1:0] n, input logic [15:0] aa,
                                     input logic [15:0] bb, input logic ci, input int done_cyc);
    exp_t e;
    e     = model(o, s, d, eff_nb(n), aa, bb, ci);
    e.cyc = 32'(done_cyc);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where this operation's done is high.
  task automatic issue(input logic [2:0] o, input logic s, input logic d, input logic [1:0] n,
                       input logic [15:0] aa, input logic [15:0] bb, input logic ci);
    int nb;
    nb = eff_nb(n);
    op = o; sub = s; dec_en = d; nbeats = n; a = aa; b = bb; c_in = ci; start = 1'b1;
    sb.push_back(expect_at(o, s, d, n, aa, bb, ci, cyc + 1 + nb));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    repeat (nb) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        if (sb.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending operation", cyc);
        end else begin
          me = sb.pop_front();
          check("result_flags", 32'({result, c_out, v_out, n_out, z_out}),
                32'({me.res, me.c, me.v, me.n, me.z}));
          check("done_cycle", cyc, me.cyc);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = OP_ORA; sub = 1'b0; dec_en = 1'b0;
    nbeats = 2'd0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, result, c_out, v_out, n_out, z_out}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(OP_ADC, 1'b0, 1'b0, 2'd2, 16'h12FF, 16'h0001, 1'b0);
    issue(OP_ADC, 1'b0, 1'b1, 2'd2, 16'h0999, 16'h0001, 1'b0);
    issue(OP_ADC, 1'b0, 1'b1, 2'd2, 16'h9999, 16'h0001, 1'b0);
    issue(OP_ADC, 1'b1, 1'b1, 2'd2, 16'h1000, 16'h0001, 1'b1);
    issue(OP_SHR, 1'b0, 1'b0, 2'd2, 16'h0001, 16'h0000, 1'b1);
    issue(OP_ASR, 1'b0, 1'b0, 2'd2, 16'h8001, 16'h0000, 1'b0);
    issue(OP_SHL, 1'b0, 1'b0, 2'd2, 16'h8000, 16'h0000, 1'b0);
    issue(OP_ADC, 1'b0, 1'b0, 2'd2, 16'h7FFF, 16'h0001, 1'b0);
    issue(OP_ORA, 1'b0, 1'b0, 2'd1, 16'h0100, 16'h0000, 1'b0);
    issue(OP_ORA, 1'b0, 1'b0, 2'd0, 16'h0100, 16'h0000, 1'b0);
    issue(OP_EOR, 1'b0, 1'b0, 2'd3, 16'hA5C3, 16'hFF0F, 1'b1);
    issue(OP_ADC, 1'b1, 1'b0, 2'd1, 16'h0080, 16'h0001, 1'b1);
    issue(OP_AND, 1'b0, 1'b0, 2'd2, 16'hF0F0, 16'h3C3C, 1'b1);

    // A start while RUN must not disturb the latched operation nor launch a second one.
    @(negedge clk);
    op = OP_ADC; sub = 1'b0; dec_en = 1'b0; nbeats = 2'd2; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
    start = 1'b1;
    sb.push_back(expect_at(OP_ADC, 1'b0, 1'b0, 2'd2, 16'h1234, 16'h1111, 1'b0, cyc + 3));
    @(negedge clk);
    op = OP_EOR; a = 16'hFFFF; b = 16'h0F0F; nbeats = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Start held through DONE relaunches with the inputs present at that edge.
    op = OP_SHL; sub = 1'b0; dec_en = 1'b0; nbeats = 2'd2; a = 16'h4321; b = 16'h0000; c_in = 1'b1;
    start = 1'b1;
    sb.push_back(expect_at(OP_SHL, 1'b0, 1'b0, 2'd2, 16'h4321, 16'h0000, 1'b1, cyc + 3));
    @(negedge clk);
    op = OP_ADC; sub = 1'b1; dec_en = 1'b1; nbeats = 2'd1; a = 16'h0042; b = 16'h0017; c_in = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back(expect_at(OP_ADC, 1'b1, 1'b1, 2'd1, 16'h0042, 16'h0017, 1'b1, cyc + 2));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-operation aborts it with no done pulse.
    op = OP_ADC; sub = 1'b0; dec_en = 1'b0; nbeats = 2'd2; a = 16'hFFFF; b = 16'h0001; c_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_abort_outputs", 32'({busy, done, result, c_out, v_out, n_out, z_out}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    while (sb.size() > 0) begin
      left = sb.pop_front();
      compared++;
      failed++;
      $display("FAIL done_timeout: got no done, required done at cycle %0d with result %h", left.cyc, left.res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
